uart_tx: RTL

//  Serial UART transmitter, counterpart of the UART receiver on the same link. Accepts one parallel

---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared defaults, state encoding and sizing helper for the UART transmitter.
// Frame-format defaults must match the receiver on the same link.
package uart_tx_pkg;

    localparam int unsigned DEF_SYSCLK_FREQUENCY_HZ = 1_000_000;
    localparam int unsigned DEF_BAUDRATE            = 100_000;
    localparam int unsigned DEF_DATA_LENGTH         = 8;
    localparam bit          DEF_DOUBLE_STOPBIT      = 1'b0;
    localparam logic [1:0]  DEF_PARITY              = 2'b00;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    // Counter width for a value range of 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Symbol-period cycle counter: wraps at CYCLES-1 and flags that cycle with o_tick.
module uart_baud_tick
    import uart_tx_pkg::*;
#(
    parameter int unsigned CYCLES = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned        CNT_W = cnt_width(CYCLES);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, sent LSB first as
// start, data, optional parity and one or two stop bits on a registered line.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned SYSCLK_FREQUENCY_HZ = DEF_SYSCLK_FREQUENCY_HZ,
    parameter int unsigned BAUDRATE            = DEF_BAUDRATE,
    parameter int unsigned DATA_LENGTH         = DEF_DATA_LENGTH,
    parameter bit          DOUBLE_STOPBIT      = DEF_DOUBLE_STOPBIT,
    parameter logic [1:0]  PARITY              = DEF_PARITY
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    input  logic                   tx_valid,
    input  logic [DATA_LENGTH-1:0] tx_data,
    output logic                   tx_ready,
    output logic                   active,
    output logic                   done,
    output logic                   serial
);

    localparam int unsigned      CLK_CYCLES_PER_SYMBOL = SYSCLK_FREQUENCY_HZ / BAUDRATE;
    localparam int unsigned      IDX_W    = cnt_width(DATA_LENGTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_LENGTH - 1);

    tx_state_e              r_state, w_state_d;
    logic [DATA_LENGTH-1:0] r_shift, w_shift_d;
    logic [IDX_W-1:0]       r_bit_idx, w_bit_idx_d;
    logic                   r_stop_idx, w_stop_idx_d;
    logic                   r_parity, w_parity_d;
    logic                   r_serial, w_serial_d;
    logic                   w_tick;
    logic                   w_clear;
    logic                   w_last_stop;

    // Counter is held at zero while idle so START always gets a full symbol.
    assign w_clear     = (r_state == StIdle);
    assign w_last_stop = !DOUBLE_STOPBIT || r_stop_idx;

    uart_baud_tick #(
        .CYCLES(CLK_CYCLES_PER_SYMBOL)
    ) u_baud_tick (
        .i_clk  (sysclk),
        .i_rst_n(rst_n),
        .i_clear(w_clear),
        .o_tick (w_tick)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_serial   <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_shift    <= w_shift_d;
            r_bit_idx  <= w_bit_idx_d;
            r_stop_idx <= w_stop_idx_d;
            r_parity   <= w_parity_d;
            r_serial   <= w_serial_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_shift_d    = r_shift;
        w_bit_idx_d  = r_bit_idx;
        w_stop_idx_d = r_stop_idx;
        w_parity_d   = r_parity;
        case (r_state)
            StIdle: begin
                if (tx_valid) begin
                    w_state_d    = StStart;
                    w_shift_d    = tx_data;
                    w_parity_d   = PARITY[0] ^ (^tx_data);
                    w_bit_idx_d  = '0;
                    w_stop_idx_d = 1'b0;
                end
            end
            StStart: begin
                if (w_tick) w_state_d = StData;
            end
            StData: begin
                if (w_tick) begin
                    w_shift_d = r_shift >> 1;
                    if (r_bit_idx == LAST_IDX) begin
                        w_bit_idx_d = '0;
                        w_state_d   = (PARITY != 2'b00) ? StParity : StStop;
                    end else begin
                        w_bit_idx_d = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            StParity: begin
                if (w_tick) w_state_d = StStop;
            end
            StStop: begin
                if (w_tick) begin
                    if (w_last_stop) begin
                        w_stop_idx_d = 1'b0;
                        w_state_d    = StIdle;
                    end else begin
                        w_stop_idx_d = 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Line level is computed from the next state so the register changes
    // exactly on symbol boundaries.
    always_comb begin
        tx_ready   = 1'b0;
        active     = 1'b0;
        done       = 1'b0;
        w_serial_d = 1'b1;
        case (r_state)
            StIdle:                    tx_ready = 1'b1;
            StStart, StData, StParity: active   = 1'b1;
            StStop: begin
                active = 1'b1;
                done   = w_tick && w_last_stop;
            end
            default: ;
        endcase
        case (w_state_d)
            StStart:  w_serial_d = 1'b0;
            StData:   w_serial_d = w_shift_d[0];
            StParity: w_serial_d = w_parity_d;
            default:  w_serial_d = 1'b1;
        endcase
    end

    assign serial = r_serial;

endmodule
